// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module  : cpu_trace_buffer
// Brief   : Post-trigger CPU fetch trace capture with oldest-first drain.
// Revision: 1.0
// ============================================================================
module cpu_trace_buffer #(
  parameter int         DEPTH     = 16,
  parameter logic [2:0] FETCH_STT = 3'd0,
  parameter int         POST_TRIG = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [63:0]              Pc_Out,
  input  logic [31:0]              opcode,
  input  logic [2:0]               STT,
  input  logic                     arm,
  input  logic                     clear,
  input  logic                     trig_en,
  input  logic [63:0]              trig_pc,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [63:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     triggered,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ARMED = 2'b01;
  localparam logic [1:0] S_POST  = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          triggered_q, triggered_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [2:0]    stt_q, stt_d;
  logic [63:0]   mem_q [DEPTH];

  logic          cap;
  logic          trig_hit;
  logic          mem_we;
  logic [63:0]   mem_wdata;
  logic          enter_done;
  logic          rd_fire;

  // One capture per fetch: only the cycle where STT first enters the fetch state.
  assign cap      = (STT == FETCH_STT) && (stt_q != FETCH_STT);
  assign trig_hit = trig_en && (Pc_Out == trig_pc);
  assign rd_fire  = rd_valid && rd_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      post_cnt_q  <= '0;
      stt_q       <= FETCH_STT;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      triggered_q <= triggered_d;
      post_cnt_q  <= post_cnt_d;
      stt_q       <= stt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= mem_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    triggered_d = triggered_q;
    post_cnt_d  = post_cnt_q;
    stt_d       = STT;
    mem_we      = 1'b0;
    mem_wdata   = {Pc_Out[31:0], opcode};
    enter_done  = 1'b0;

    if (clear) begin
      state_d     = S_IDLE;
      count_d     = '0;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d     = S_ARMED;
            wr_ptr_d    = '0;
            count_d     = '0;
            triggered_d = 1'b0;
          end
        end
        S_ARMED: begin
          if (cap) begin
            mem_we = 1'b1;
            if (trig_hit) begin
              triggered_d = 1'b1;
              if (POST_TRIG == 0) begin
                enter_done = 1'b1;
              end else begin
                post_cnt_d = AW'(POST_TRIG);
                state_d    = S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (cap) begin
            mem_we     = 1'b1;
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == AW'(1)) begin
              enter_done = 1'b1;
            end
          end
        end
        default: begin
          if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
            if (count_q == CW'(1)) begin
              state_d = S_IDLE;
            end
          end
        end
      endcase

      if (mem_we) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q != C_FULL) begin
          count_d = count_q + 1'b1;
        end
      end

      // A full buffer has wrapped, so the oldest entry sits at the write pointer.
      if (enter_done) begin
        state_d  = S_DONE;
        rd_ptr_d = (count_d == C_FULL) ? wr_ptr_d : '0;
      end
    end
  end

  always_comb begin
    state     = state_q;
    count     = count_q;
    triggered = triggered_q;
    rd_valid  = (state_q == S_DONE) && (count_q != '0);
    rd_data   = mem_q[rd_ptr_q];
  end

endmodule
`default_nettype wire
